exp6_unidade_controle: RTL

Control unit for the Experience 6 memory game. Moore FSM that drives `exp6_fluxo_dados`: it consumes the datapath status flags (`jogada_feita`, `jogada_correta`, `enderecoIgualRodada`, `fimL`, `timeout`) and produces every datapath control strobe. It also reports game outcome and debug state. Top level wires it one-to-one with the datapath.

---
 rtl/exp6_unidade_controle.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/exp6_unidade_controle.sv
// rtl/exp6_unidade_controle.sv - Moore control FSM for the memory game; optional UC_TIMEOUT_EN enables the play timeout
module exp6_unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       jogada_feita,
    input  logic       jogada_correta,
    input  logic       enderecoIgualRodada,
    input  logic       fimL,
    input  logic       timeout,
    output logic       zeraCR,
    output logic       zeraE,
    output logic       contaCR,
    output logic       contaE,
    output logic       limpaRC,
    output logic       registraRC,
    output logic       zeraLeds,
    output logic       registraLeds,
    output logic       contaT,
    output logic       led_selector,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    localparam logic [3:0] IDLE             = 4'h0;
    localparam logic [3:0] PREPARACAO       = 4'h1;
    localparam logic [3:0] INICIO           = 4'h2;
    localparam logic [3:0] ESPERA           = 4'h3;
    localparam logic [3:0] REGISTRA         = 4'h4;
    localparam logic [3:0] COMPARACAO       = 4'h5;
    localparam logic [3:0] PROXIMA_JOGADA   = 4'h6;
    localparam logic [3:0] ULTIMA_JOGADA    = 4'h7;
    localparam logic [3:0] PROXIMA_RODADA   = 4'h8;
    localparam logic [3:0] FIM_A            = 4'hA;
    localparam logic [3:0] ATUALIZA_MEMORIA = 4'hB;
    localparam logic [3:0] FIM_T            = 4'hD;
    localparam logic [3:0] FIM_E            = 4'hE;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       timeout_hit;

`ifdef UC_TIMEOUT_EN
    assign timeout_hit = timeout;
`else
    // Timeout input is deliberately ignored in this build; espera waits forever.
    logic unused_timeout;
    assign unused_timeout = timeout;
    assign timeout_hit    = 1'b0;
`endif

    // State register; reset drops straight to idle without waiting for a clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; timeout beats a play in espera, a wrong play beats the last-play check.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:             state_d = jogar ? PREPARACAO : IDLE;
            PREPARACAO:       state_d = INICIO;
            INICIO:           state_d = ESPERA;
            ESPERA: begin
                if (timeout_hit)       state_d = FIM_T;
                else if (jogada_feita) state_d = REGISTRA;
                else                   state_d = ESPERA;
            end
            REGISTRA:         state_d = ATUALIZA_MEMORIA;
            ATUALIZA_MEMORIA: state_d = COMPARACAO;
            COMPARACAO: begin
                if (!jogada_correta)          state_d = FIM_E;
                else if (enderecoIgualRodada) state_d = ULTIMA_JOGADA;
                else                          state_d = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA:   state_d = ESPERA;
            ULTIMA_JOGADA:    state_d = fimL ? FIM_A : PROXIMA_RODADA;
            PROXIMA_RODADA:   state_d = INICIO;
            FIM_A:            state_d = jogar ? PREPARACAO : FIM_A;
            FIM_T:            state_d = jogar ? PREPARACAO : FIM_T;
            FIM_E:            state_d = jogar ? PREPARACAO : FIM_E;
            default:          state_d = IDLE;
        endcase
    end

    // Moore output decode from the state register only; unused codes drive all zeros.
    always_comb begin
        zeraCR       = 1'b0;
        zeraE        = 1'b0;
        contaCR      = 1'b0;
        contaE       = 1'b0;
        limpaRC      = 1'b0;
        registraRC   = 1'b0;
        zeraLeds     = 1'b0;
        registraLeds = 1'b0;
        contaT       = 1'b0;
        led_selector = 1'b0;
        pronto       = 1'b0;
        ganhou       = 1'b0;
        perdeu       = 1'b0;
        db_timeout   = 1'b0;
        db_estado    = state_q;
        case (state_q)
            IDLE: begin
                zeraCR   = 1'b1;
                zeraE    = 1'b1;
                limpaRC  = 1'b1;
                zeraLeds = 1'b1;
            end
            PREPARACAO: begin
                zeraCR       = 1'b1;
                zeraE        = 1'b1;
                limpaRC      = 1'b1;
                zeraLeds     = 1'b1;
                led_selector = 1'b1;
            end
            INICIO: begin
                zeraE        = 1'b1;
                registraLeds = 1'b1;
                led_selector = 1'b1;
            end
            ESPERA: begin
`ifdef UC_TIMEOUT_EN
                contaT = 1'b1;
`endif
            end
            REGISTRA: begin
                registraRC   = 1'b1;
                registraLeds = 1'b1;
            end
            PROXIMA_JOGADA: contaE = 1'b1;
            PROXIMA_RODADA: begin
                contaCR      = 1'b1;
                led_selector = 1'b1;
            end
            FIM_A: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            FIM_T: begin
                pronto = 1'b1;
                perdeu = 1'b1;
`ifdef UC_TIMEOUT_EN
                db_timeout = 1'b1;
`endif
            end
            FIM_E: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
